// File: rtl/ex_muldiv_unit.sv
// EX-stage iterative multiply/divide unit: shift-add multiply, restoring divide.
// Define MULDIV_DIV0_FAST_EN to finish divide-by-zero in one cycle with div_zero set.
module ex_muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs_val,
  input  logic [XLEN-1:0] rt_val,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic            div_zero,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] opnd;
  logic            is_div;
  logic            neg_main;
  logic            neg_rem;

  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;

  assign a_neg = ~op[0] & rs_val[XLEN-1];
  assign b_neg = ~op[0] & rt_val[XLEN-1];
  assign a_abs = a_neg ? -rs_val : rs_val;
  assign b_abs = b_neg ? -rt_val : rt_val;

  // acc_hi:acc_lo is the partial product, or remainder:quotient
  logic [XLEN:0]     add_sum;
  logic [XLEN:0]     shl;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   nxt_hi;
  logic [XLEN-1:0]   nxt_lo;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_n;

  always_comb begin
    add_sum = {1'b0, acc_hi}
            + (acc_lo[0] ? {1'b0, opnd} : '0);
    shl     = {acc_hi, acc_lo[XLEN-1]};
    diff    = shl - {1'b0, opnd};
    nxt_hi  = add_sum[XLEN:1];
    nxt_lo  = {add_sum[0], acc_lo[XLEN-1:1]};
    if (is_div) begin
      if (diff[XLEN]) begin
        nxt_hi = shl[XLEN-1:0];
        nxt_lo = {acc_lo[XLEN-2:0], 1'b0};
      end else begin
        nxt_hi = diff[XLEN-1:0];
        nxt_lo = {acc_lo[XLEN-2:0], 1'b1};
      end
    end
  end

  assign prod   = {acc_hi, acc_lo};
  assign prod_n = -prod;

  assign busy  = (state != IDLE);
  assign stall = start | (busy & ~done);

`ifndef MULDIV_DIV0_FAST_EN
  assign div_zero = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
`ifdef MULDIV_DIV0_FAST_EN
      div_zero <= 1'b0;
`endif
    end else if (flush) begin
      state    <= IDLE;
      done     <= 1'b0;
`ifdef MULDIV_DIV0_FAST_EN
      div_zero <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
`ifdef MULDIV_DIV0_FAST_EN
            if (op[1] && rt_val == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= RUN;
            end
`else
            state <= RUN;
`endif
            cnt      <= '0;
            acc_hi   <= '0;
            acc_lo   <= op[1] ? a_abs : b_abs;
            opnd     <= op[1] ? b_abs : a_abs;
            is_div   <= op[1];
            neg_main <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
          end
        end
        RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_W'(XLEN - 1))
            state <= FIX;
        end
        FIX: begin
          if (is_div) begin
            lo <= neg_main ? -acc_lo : acc_lo;
            hi <= neg_rem ? -acc_hi : acc_hi;
          end else if (neg_main) begin
            {hi, lo} <= prod_n;
          end else begin
            {hi, lo} <= prod;
          end
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
`ifdef MULDIV_DIV0_FAST_EN
          div_zero <= 1'b0;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
